// File: rtl/imem_pkg.sv
// imem_pkg
//   Shared types and defaults for the instruction-ROM arbiter slice.
//   ROM_BASE_DEF / ROM_BYTES_DEF : default ROM window (4 KiB at 0xBFC00000)
//   port_e                       : requester identity, used for round-robin memory
//   imem_rsp_t                   : one buffered response (valid, fault flag, data word)
package imem_pkg;

  localparam logic [31:0] ROM_BASE_DEF  = 32'hBFC00000;
  localparam int          ROM_BYTES_DEF = 4096;

  typedef enum logic {
    PORT_IF,
    PORT_LS
  } port_e;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
//   One requester's request/response handshake bundle.
//   master : requester side (drives req_valid, req_addr, rsp_ready)
//   slave  : arbiter side   (drives req_ready, rsp_valid, rsp_data, rsp_err)
interface imem_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     req_valid;
  logic                     req_ready;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     rsp_err;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_rsp_buf.sv
// imem_rsp_buf
//   One-entry response holding register for a single requester port.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture err_in/data_in as a new valid response
//   drain             : consumer took the held response this cycle
//   clear             : discard the held response (flush)
//   err_in, data_in   : response being loaded
//   rsp               : held response (valid/err/data), zero when empty
module imem_rsp_buf
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic        err_in,
  input  logic [31:0] data_in,
  output imem_rsp_t   rsp
);

  // Clear wins over everything; a load in the same cycle as a drain simply
  // replaces the old word, which is what gives 1/cycle throughput per port.
  // Emptied entries go back to all-zero so data/err read 0 when not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp <= '0;
    end else if (clear) begin
      rsp <= '0;
    end else if (load) begin
      rsp <= '{valid: 1'b1, err: err_in, data: data_in};
    end else if (drain) begin
      rsp <= '0;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares one combinational instruction ROM between the fetch stage (IF) and
//   the load/store unit (LS) with round-robin arbitration, range/alignment
//   fault checking, a one-entry response buffer per port and an IF flush.
//   clk, rst  : clock, asynchronous active-high reset
//   if_port   : IF request/response handshake (slave side)
//   ls_port   : LS request/response handshake (slave side)
//   if_flush  : drop any unconsumed IF response, block IF grant this cycle
//   mem_addr  : word-aligned byte offset into the ROM (0 when idle)
//   mem_dout  : ROM word at mem_addr, combinational
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = ROM_BASE_DEF,
  parameter int                       ROM_BYTES     = ROM_BYTES_DEF,
  localparam int                      OFF_W         = $clog2(ROM_BYTES)
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_arbiter_if.slave         if_port,
  imem_arbiter_if.slave         ls_port,
  input  logic                  if_flush,
  output logic [OFF_W-1:0]      mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  // Range bounds carry one extra bit so ROM_BASE+ROM_BYTES near the top of
  // the address space cannot wrap around.
  localparam logic [ADDRESS_WIDTH:0] ROM_LO    = {1'b0, ROM_BASE};
  localparam logic [ADDRESS_WIDTH:0] ROM_HI    = ROM_LO + (ADDRESS_WIDTH+1)'(ROM_BYTES - 4);
  localparam logic [OFF_W-1:0]       BASE_LO   = ROM_BASE[OFF_W-1:0];
  localparam logic [OFF_W-1:0]       WORD_MASK = ~OFF_W'(3);

  port_e                    rr_last;
  imem_rsp_t                if_rsp;
  imem_rsp_t                ls_rsp;
  logic                     if_drain;
  logic                     ls_drain;
  logic                     if_elig;
  logic                     ls_elig;
  logic                     grant_if;
  logic                     grant_ls;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [ADDRESS_WIDTH:0]   sel_ext;
  logic                     sel_err;
  logic [OFF_W-1:0]         sel_off;
  logic [DATA_WIDTH-1:0]    sel_data;

  // A port may be granted only when its buffer will be free at the next edge,
  // i.e. empty now or being consumed now. Flush blocks IF entirely.
  // On a tie the port that was not granted last time wins.
  always_comb begin
    if_drain = if_rsp.valid & if_port.rsp_ready;
    ls_drain = ls_rsp.valid & ls_port.rsp_ready;
    if_elig  = if_port.req_valid & (~if_rsp.valid | if_drain) & ~if_flush;
    ls_elig  = ls_port.req_valid & (~ls_rsp.valid | ls_drain);
    grant_if = if_elig & (~ls_elig | (rr_last == PORT_LS));
    grant_ls = ls_elig & ~grant_if;
  end

  // Address decode for whichever port holds the grant: fault check, ROM
  // offset and the word that will be buffered (forced to 0 on a fault).
  always_comb begin
    sel_addr = grant_ls ? ls_port.req_addr : if_port.req_addr;
    sel_ext  = {1'b0, sel_addr};
    sel_err  = (sel_ext < ROM_LO) | (sel_ext > ROM_HI) | (sel_addr[1:0] != 2'b00);
    sel_off  = (sel_addr[OFF_W-1:0] - BASE_LO) & WORD_MASK;
    sel_data = sel_err ? '0 : mem_dout;
    mem_addr = (grant_if | grant_ls) ? sel_off : '0;
  end

  // Round-robin memory only moves when someone is actually granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= PORT_LS;
    end else if (grant_if) begin
      rr_last <= PORT_IF;
    end else if (grant_ls) begin
      rr_last <= PORT_LS;
    end
  end

  imem_rsp_buf u_if_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_if),
    .drain   (if_drain),
    .clear   (if_flush),
    .err_in  (sel_err),
    .data_in (sel_data),
    .rsp     (if_rsp)
  );

  imem_rsp_buf u_ls_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (grant_ls),
    .drain   (ls_drain),
    .clear   (1'b0),
    .err_in  (sel_err),
    .data_in (sel_data),
    .rsp     (ls_rsp)
  );

  assign if_port.req_ready = grant_if;
  assign if_port.rsp_valid = if_rsp.valid;
  assign if_port.rsp_err   = if_rsp.err;
  assign if_port.rsp_data  = if_rsp.data;

  assign ls_port.req_ready = grant_ls;
  assign ls_port.rsp_valid = ls_rsp.valid;
  assign ls_port.rsp_err   = ls_rsp.err;
  assign ls_port.rsp_data  = ls_rsp.data;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter
//   Self-checking bench for imem_arbiter: a directed vector table, a
//   hand-written async-reset sequence, then randomized traffic, all compared
//   against a queue-based model of the arbiter's externally visible rules.
module tb_imem_arbiter;
  import imem_pkg::*;

  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_flush;
  logic [11:0] mem_addr;
  logic [31:0] mem_dout;

  imem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) ifb ();
  imem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) lsb ();

  imem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .if_port  (ifb),
    .ls_port  (lsb),
    .if_flush (if_flush),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  // ROM contents: word 0 is the reset instruction, the rest a fixed pattern.
  function automatic logic [31:0] rom_word(input logic [11:0] off);
    if (off[11:2] == 10'd0) return 32'h00500093;
    return {off[11:2], 22'h0} ^ 32'h13579BDF ^ {22'h0, off[11:2]};
  endfunction

  assign mem_dout = rom_word(mem_addr);

  typedef struct {
    logic        err;
    logic [31:0] data;
  } exp_rsp_t;

  typedef struct {
    logic        ifv;
    logic [31:0] ifa;
    logic        fl;
    logic        ifr;
    logic        lsv;
    logic [31:0] lsa;
    logic        lsr;
    logic        e_ifrdy;
    logic        e_lsrdy;
    logic        e_ifval;
    logic        e_iferr;
    logic        e_lsval;
    logic        e_lserr;
  } vec_t;

  // Model state: each port's pending response as a queue (at most one entry)
  // and which port was granted most recently.
  exp_rsp_t if_q[$];
  exp_rsp_t ls_q[$];
  bit       last_ls;

  int checks = 0;
  int errors = 0;
  vec_t tab[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_fault(input logic [31:0] a);
    longint ua;
    ua = longint'(a);
    return (ua < longint'(BASE)) || (ua > longint'(BASE) + 4096 - 4) || (a % 4 != 0);
  endfunction

  function automatic exp_rsp_t make_rsp(input logic [31:0] a);
    exp_rsp_t r;
    logic [31:0] off;
    off = a - BASE;
    r.err  = is_fault(a);
    r.data = r.err ? 32'h0 : rom_word(off[11:0]);
    return r;
  endfunction

  function automatic vec_t mk(input logic ifv, input logic [31:0] ifa, input logic fl,
                              input logic ifr, input logic lsv, input logic [31:0] lsa,
                              input logic lsr, input logic e_ifrdy, input logic e_lsrdy,
                              input logic e_ifval, input logic e_iferr,
                              input logic e_lsval, input logic e_lserr);
    vec_t v;
    v.ifv = ifv; v.ifa = ifa; v.fl = fl; v.ifr = ifr;
    v.lsv = lsv; v.lsa = lsa; v.lsr = lsr;
    v.e_ifrdy = e_ifrdy; v.e_lsrdy = e_lsrdy;
    v.e_ifval = e_ifval; v.e_iferr = e_iferr;
    v.e_lsval = e_lsval; v.e_lserr = e_lserr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    ifb.req_valid = v.ifv;
    ifb.req_addr  = v.ifa;
    if_flush      = v.fl;
    ifb.rsp_ready = v.ifr;
    lsb.req_valid = v.lsv;
    lsb.req_addr  = v.lsa;
    lsb.rsp_ready = v.lsr;
  endtask

  task automatic resetModel();
    if_q.delete();
    ls_q.delete();
    last_ls = 1'b1;
  endtask

  // Called mid-cycle: compare the DUT with the model for the current inputs,
  // then advance the model to what the next clock edge should produce.
  task automatic checkOutput(input string tag);
    bit          if_drain, ls_drain, if_want, ls_want, win_if, win_ls;
    logic [31:0] off;
    logic [11:0] exp_addr;
    if_drain = (if_q.size() != 0) && ifb.rsp_ready;
    ls_drain = (ls_q.size() != 0) && lsb.rsp_ready;
    if_want  = ifb.req_valid && !if_flush && (if_q.size() == 0 || if_drain);
    ls_want  = lsb.req_valid && (ls_q.size() == 0 || ls_drain);
    if (if_want && ls_want) begin
      win_if = last_ls;
      win_ls = !last_ls;
    end else begin
      win_if = if_want;
      win_ls = ls_want;
    end

    check({tag, " if_req_ready"}, 32'(ifb.req_ready), 32'(win_if));
    check({tag, " ls_req_ready"}, 32'(lsb.req_ready), 32'(win_ls));
    check({tag, " if_rsp_valid"}, 32'(ifb.rsp_valid), 32'(if_q.size() != 0));
    check({tag, " ls_rsp_valid"}, 32'(lsb.rsp_valid), 32'(ls_q.size() != 0));
    if (if_q.size() != 0) begin
      check({tag, " if_rsp_data"}, ifb.rsp_data, if_q[0].data);
      check({tag, " if_rsp_err"}, 32'(ifb.rsp_err), 32'(if_q[0].err));
    end
    if (ls_q.size() != 0) begin
      check({tag, " ls_rsp_data"}, lsb.rsp_data, ls_q[0].data);
      check({tag, " ls_rsp_err"}, 32'(lsb.rsp_err), 32'(ls_q[0].err));
    end
    exp_addr = 12'h0;
    if (win_if || win_ls) begin
      off = (win_if ? ifb.req_addr : lsb.req_addr) - BASE;
      exp_addr = off[11:0] & 12'hFFC;
    end
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));

    if (if_flush) if_q.delete();
    else if (if_drain) void'(if_q.pop_front());
    if (win_if) if_q.push_back(make_rsp(ifb.req_addr));
    if (ls_drain) void'(ls_q.pop_front());
    if (win_ls) ls_q.push_back(make_rsp(lsb.req_addr));
    if (win_if) last_ls = 1'b0;
    if (win_ls) last_ls = 1'b1;
  endtask

  task automatic tabCheck(input vec_t v, input int i);
    string t;
    t = $sformatf("vec%0d", i);
    check({t, " tab if_req_ready"}, 32'(ifb.req_ready), 32'(v.e_ifrdy));
    check({t, " tab ls_req_ready"}, 32'(lsb.req_ready), 32'(v.e_lsrdy));
    check({t, " tab if_rsp_valid"}, 32'(ifb.rsp_valid), 32'(v.e_ifval));
    check({t, " tab ls_rsp_valid"}, 32'(lsb.rsp_valid), 32'(v.e_lsval));
    if (v.e_ifval) check({t, " tab if_rsp_err"}, 32'(ifb.rsp_err), 32'(v.e_iferr));
    if (v.e_lsval) begin
      check({t, " tab ls_rsp_err"}, 32'(lsb.rsp_err), 32'(v.e_lserr));
      if (v.e_lserr) check({t, " tab ls_rsp_data"}, lsb.rsp_data, 32'h0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return BASE + 32'(4 * $urandom_range(0, 1023));
      1:       return BASE + 32'hFFC;
      2:       return BASE + 32'h1000;
      3:       return BASE + 32'($urandom_range(0, 4095));
      4:       return $urandom;
      default: return BASE - 32'd4;
    endcase
  endfunction

  initial begin
    vec_t v;

    // Directed table; each row is one cycle, expectations observed mid-cycle.
    //            ifv ifa           fl ifr lsv lsa            lsr | ifrdy lsrdy ifval iferr lsval lserr
    tab[0]  = mk(1, BASE,           0, 1,  0, 32'h0,          1,    1, 0, 0, 0, 0, 0);
    tab[1]  = mk(0, 32'h0,          0, 1,  0, 32'h0,          1,    0, 0, 1, 0, 0, 0);
    tab[2]  = mk(1, BASE + 32'h4,   0, 1,  1, BASE + 32'h8,   1,    0, 1, 0, 0, 0, 0);
    tab[3]  = mk(1, BASE + 32'h4,   0, 1,  1, BASE + 32'hC,   1,    1, 0, 0, 0, 1, 0);
    tab[4]  = mk(1, BASE + 32'h10,  0, 1,  1, BASE + 32'hC,   1,    0, 1, 1, 0, 0, 0);
    tab[5]  = mk(1, BASE + 32'h10,  0, 1,  1, BASE + 32'h14,  1,    1, 0, 0, 0, 1, 0);
    tab[6]  = mk(0, 32'h0,          0, 1,  1, BASE + 32'h1000,1,    0, 1, 1, 0, 0, 0);
    tab[7]  = mk(0, 32'h0,          0, 1,  1, BASE + 32'h2,   1,    0, 1, 0, 0, 1, 1);
    tab[8]  = mk(0, 32'h0,          0, 1,  1, 32'h0,          1,    0, 1, 0, 0, 1, 1);
    tab[9]  = mk(0, 32'h0,          0, 1,  1, BASE + 32'hFFC, 1,    0, 1, 0, 0, 1, 1);
    tab[10] = mk(0, 32'h0,          0, 1,  0, 32'h0,          1,    0, 0, 0, 0, 1, 0);
    tab[11] = mk(1, BASE + 32'h20,  0, 0,  0, 32'h0,          1,    1, 0, 0, 0, 0, 0);
    tab[12] = mk(1, BASE + 32'h24,  0, 0,  0, 32'h0,          1,    0, 0, 1, 0, 0, 0);
    tab[13] = mk(1, BASE + 32'h24,  0, 0,  0, 32'h0,          1,    0, 0, 1, 0, 0, 0);
    tab[14] = mk(1, BASE + 32'h24,  0, 1,  0, 32'h0,          1,    1, 0, 1, 0, 0, 0);
    tab[15] = mk(0, 32'h0,          0, 0,  0, 32'h0,          1,    0, 0, 1, 0, 0, 0);
    tab[16] = mk(1, BASE + 32'h28,  1, 0,  1, BASE + 32'h2C,  1,    0, 1, 1, 0, 0, 0);
    tab[17] = mk(0, 32'h0,          0, 1,  0, 32'h0,          1,    0, 0, 0, 0, 1, 0);

    // Reset and check the cleared outputs.
    rst = 1'b1;
    applyStimulus(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset if_rsp_valid", 32'(ifb.rsp_valid), 32'h0);
    check("reset if_rsp_data", ifb.rsp_data, 32'h0);
    check("reset if_rsp_err", 32'(ifb.rsp_err), 32'h0);
    check("reset ls_rsp_valid", 32'(lsb.rsp_valid), 32'h0);
    check("reset ls_rsp_data", lsb.rsp_data, 32'h0);
    check("reset ls_rsp_err", 32'(lsb.rsp_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tab[i]);
      @(negedge clk);
      tabCheck(tab[i], i);
      if (i == 1) check("vec1 first fetch data", ifb.rsp_data, 32'h00500093);
      checkOutput($sformatf("vec%0d", i));
      @(posedge clk);
      #1;
    end

    // Fill both buffers, then reset between edges: valids drop immediately.
    v = mk(1, BASE + 32'h30, 0, 0, 1, BASE + 32'h34, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("fill%0d", i));
      @(posedge clk);
      #1;
    end
    applyStimulus(mk(0, 32'h0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("prereset if_rsp_valid", 32'(ifb.rsp_valid), 32'h1);
    check("prereset ls_rsp_valid", 32'(lsb.rsp_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async rst if_rsp_valid", 32'(ifb.rsp_valid), 32'h0);
    check("async rst ls_rsp_valid", 32'(lsb.rsp_valid), 32'h0);
    check("async rst if_rsp_data", ifb.rsp_data, 32'h0);
    check("async rst ls_rsp_data", lsb.rsp_data, 32'h0);
    resetModel();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(mk(1, BASE + 32'h40, 0, 1, 1, BASE + 32'h44, 1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("post-reset tie if_req_ready", 32'(ifb.req_ready), 32'h1);
    check("post-reset tie ls_req_ready", 32'(lsb.req_ready), 32'h0);
    checkOutput("post-reset");
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      v = mk(1'($urandom_range(0, 3) != 0), rand_addr(), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), rand_addr(),
             1'($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0, 0);
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("rand%0d", i));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
